// File: rtl/uart_receiver.sv
// UART receive path: 2-flop input synchroniser, 16x oversampling tick generator and frame FSM.
// Define UART_RX_PARITY_EN to receive an even-parity bit between data bit 7 and the stop bit.
module uart_receiver #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int OVERSAMPLE  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Rx_EN,
  input  logic       RxD,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_FERROR,
  output logic       Rx_PERROR
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  // Tick indices within one bit period: centre of the start bit, and the last tick of a bit.
  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

  // Clocks per oversample tick for each baud_select code, truncated.
  function automatic logic [15:0] divider_for(input logic [2:0] sel);
    int baud;
    case (sel)
      3'd0:    baud = 300;
      3'd1:    baud = 1200;
      3'd2:    baud = 4800;
      3'd3:    baud = 9600;
      3'd4:    baud = 19200;
      3'd5:    baud = 38400;
      3'd6:    baud = 57600;
      default: baud = 115200;
    endcase
    return 16'(CLK_FREQ_HZ / (OVERSAMPLE * baud));
  endfunction

  logic        rxd_meta;
  logic        rxd_s;
  logic [2:0]  state;
  logic [15:0] divider_q;
  logic [15:0] tick_cnt;
  logic [3:0]  bit_tick;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_q;
  logic        tick;
  logic        bit_end;

  // NOTE: both synchroniser stages use <=; a blocking assignment here would merge them into one flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= RxD;
      rxd_s    <= rxd_meta;
    end
  end

  assign tick    = (state != IDLE) && (tick_cnt == divider_q - 16'd1);
  assign bit_end = tick && (bit_tick == LAST_TICK);

`ifdef UART_RX_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      parity_q  <= 1'b0;
      Rx_PERROR <= 1'b0;
    end else if (Rx_EN) begin
      if (state == PARITY && bit_end) parity_q <= rxd_s;
      if (state == STOP && bit_end)   Rx_PERROR <= (^shift_q) ^ parity_q;
    end
  end
`else
  assign Rx_PERROR = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      divider_q <= '0;
      tick_cnt  <= '0;
      bit_tick  <= '0;
      bit_idx   <= '0;
      shift_q   <= '0;
      Rx_DATA   <= '0;
      Rx_VALID  <= 1'b0;
      Rx_FERROR <= 1'b0;
    end else begin
      Rx_VALID <= 1'b0;
      if (!Rx_EN) begin
        // Abort whatever frame is in flight; the held outputs keep their values.
        state    <= IDLE;
        tick_cnt <= '0;
        bit_tick <= '0;
        bit_idx  <= '0;
      end else begin
        tick_cnt <= (state == IDLE || tick) ? 16'd0 : tick_cnt + 16'd1;
        if (tick) bit_tick <= bit_tick + 4'd1;

        case (state)
          IDLE: begin
            bit_tick <= '0;
            bit_idx  <= '0;
            if (!rxd_s) begin
              state     <= START;
              divider_q <= divider_for(baud_select);
            end
          end

          START: begin
            if (tick && bit_tick == MID_TICK) begin
              bit_tick <= '0;
              // A line that is high again at mid start bit was only a glitch.
              state    <= rxd_s ? IDLE : DATA;
            end
          end

          DATA: begin
            if (bit_end) begin
              shift_q <= {rxd_s, shift_q[7:1]};
              bit_idx <= bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
              if (bit_idx == 3'd7) state <= PARITY;
`else
              if (bit_idx == 3'd7) state <= STOP;
`endif
            end
          end

`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (bit_end) state <= STOP;
          end
`endif

          STOP: begin
            // Return to IDLE mid stop bit so a start edge right after it is caught.
            if (bit_end) begin
              state     <= IDLE;
              Rx_DATA   <= shift_q;
              Rx_FERROR <= ~rxd_s;
              Rx_VALID  <= 1'b1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: drives serial frames and compares each Rx_VALID
// pulse against a frame-level model of the expected byte and error flags.
module tb_uart_receiver;

  localparam int CLK_HZ = 10_000_000;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FRAME_BITS = PAR_EN ? 11 : 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] baud_select;
  logic       Rx_EN;
  logic       RxD;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_FERROR;
  logic       Rx_PERROR;

  int checks   = 0;
  int failures = 0;

  // Every observed Rx_VALID cycle as {data, ferror, perror}.
  logic [9:0] got[$];

  uart_receiver #(
    .CLK_FREQ_HZ(CLK_HZ),
    .OVERSAMPLE (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .baud_select(baud_select),
    .Rx_EN      (Rx_EN),
    .RxD        (RxD),
    .Rx_DATA    (Rx_DATA),
    .Rx_VALID   (Rx_VALID),
    .Rx_FERROR  (Rx_FERROR),
    .Rx_PERROR  (Rx_PERROR)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (Rx_VALID) got.push_back({Rx_DATA, Rx_FERROR, Rx_PERROR});
  end

  // Line-side bit period in clocks: 16 oversample ticks of the truncated divider.
  function automatic int bit_clks(input logic [2:0] sel);
    int baud;
    case (sel)
      3'd0:    baud = 300;
      3'd1:    baud = 1200;
      3'd2:    baud = 4800;
      3'd3:    baud = 9600;
      3'd4:    baud = 19200;
      3'd5:    baud = 38400;
      3'd6:    baud = 57600;
      default: baud = 115200;
    endcase
    return 16 * (CLK_HZ / (16 * baud));
  endfunction

  // What a receiver should report for a frame carrying these fields.
  function automatic logic [9:0] model(input logic [7:0] d, input logic par, input logic stop);
    logic perr;
    perr = PAR_EN ? ((^d) ^ par) : 1'b0;
    return {d, ~stop, perr};
  endfunction

  // Drives the first nbits of a frame at the given rate, then leaves the line idle.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int nbits, input logic [2:0] sel);
    logic [10:0] f;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (PAR_EN) begin
      f[9]  = par;
      f[10] = stop;
    end else begin
      f[9]  = stop;
      f[10] = 1'b1;
    end
    for (int i = 0; i < nbits && i < FRAME_BITS; i++) begin
      RxD = f[i];
      repeat (bit_clks(sel)) @(negedge clk);
    end
    RxD = 1'b1;
  endtask

  task automatic idle_bits(input int n, input logic [2:0] sel);
    repeat (n * bit_clks(sel)) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Rx_EN = 1'b0;
    RxD = 1'b1;
    baud_select = 3'd7;
    repeat (3) @(negedge clk);
    checks++;
    if (Rx_DATA !== 8'h00) begin failures++; $display("FAIL reset_data got=%h want=00", Rx_DATA); end
    checks++;
    if (Rx_VALID !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", Rx_VALID); end
    checks++;
    if (Rx_FERROR !== 1'b0) begin failures++; $display("FAIL reset_ferror got=%b want=0", Rx_FERROR); end
    checks++;
    if (Rx_PERROR !== 1'b0) begin failures++; $display("FAIL reset_perror got=%b want=0", Rx_PERROR); end
    reset = 1'b0;
    Rx_EN = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_clean_frame();
    logic [9:0] want;
    got.delete();
    want = model(8'hA5, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b0, 1'b1, FRAME_BITS, 3'd7);
    idle_bits(2, 3'd7);
    checks++;
    if (got.size() !== 1) begin
      failures++; $display("FAIL clean_frame pulses got=%0d want=1", got.size());
    end else begin
      checks++;
      if (got[0] !== want) begin failures++; $display("FAIL clean_frame frame got=%h want=%h", got[0], want); end
    end
    checks++;
    if (Rx_DATA !== 8'hA5) begin failures++; $display("FAIL clean_frame hold got=%h want=a5", Rx_DATA); end
  endtask

  task automatic test_parity_error();
    logic [9:0] want;
    got.delete();
    want = model(8'h01, 1'b0, 1'b1);
    send_frame(8'h01, 1'b0, 1'b1, FRAME_BITS, 3'd7);
    idle_bits(2, 3'd7);
    checks++;
    if (got.size() !== 1) begin
      failures++; $display("FAIL parity_error pulses got=%0d want=1", got.size());
    end else begin
      checks++;
      if (got[0] !== want) begin failures++; $display("FAIL parity_error frame got=%h want=%h", got[0], want); end
    end
  endtask

  task automatic test_framing_error();
    logic [9:0] want [2];
    got.delete();
    baud_select = 3'd3;
    want[0] = model(8'h3C, 1'b0, 1'b0);
    want[1] = model(8'h42, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b0, FRAME_BITS, 3'd3);
    idle_bits(2, 3'd3);
    send_frame(8'h42, 1'b0, 1'b1, FRAME_BITS, 3'd3);
    idle_bits(1, 3'd3);
    checks++;
    if (got.size() !== 2) begin
      failures++; $display("FAIL framing_error pulses got=%0d want=2", got.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got[i] !== want[i]) begin
          failures++; $display("FAIL framing_error frame%0d got=%h want=%h", i, got[i], want[i]);
        end
      end
    end
    baud_select = 3'd7;
  endtask

  task automatic test_glitch();
    logic [9:0] want;
    got.delete();
    RxD = 1'b0;
    repeat (4 * bit_clks(3'd7) / 16) @(negedge clk);
    RxD = 1'b1;
    idle_bits(2, 3'd7);
    checks++;
    if (got.size() !== 0) begin failures++; $display("FAIL glitch pulses got=%0d want=0", got.size()); end
    got.delete();
    want = model(8'h7E, 1'b0, 1'b1);
    send_frame(8'h7E, 1'b0, 1'b1, FRAME_BITS, 3'd7);
    idle_bits(2, 3'd7);
    checks++;
    if (got.size() !== 1) begin
      failures++; $display("FAIL glitch_recover pulses got=%0d want=1", got.size());
    end else begin
      checks++;
      if (got[0] !== want) begin failures++; $display("FAIL glitch_recover frame got=%h want=%h", got[0], want); end
    end
  endtask

  task automatic test_rx_en_abort();
    logic [9:0] want;
    send_frame(8'h99, 1'b0, 1'b1, FRAME_BITS, 3'd7);
    idle_bits(2, 3'd7);
    got.delete();
    // Start bit plus data bits 0..3, then disable.
    send_frame(8'hFF, 1'b0, 1'b1, 5, 3'd7);
    Rx_EN = 1'b0;
    repeat (3) @(negedge clk);
    Rx_EN = 1'b1;
    idle_bits(2, 3'd7);
    // A whole frame while disabled must also be ignored.
    Rx_EN = 1'b0;
    send_frame(8'h55, 1'b0, 1'b1, FRAME_BITS, 3'd7);
    idle_bits(1, 3'd7);
    Rx_EN = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (got.size() !== 0) begin failures++; $display("FAIL rx_en_abort pulses got=%0d want=0", got.size()); end
    checks++;
    if (Rx_DATA !== 8'h99) begin failures++; $display("FAIL rx_en_abort hold got=%h want=99", Rx_DATA); end
    got.delete();
    want = model(8'h81, 1'b0, 1'b1);
    send_frame(8'h81, 1'b0, 1'b1, FRAME_BITS, 3'd7);
    idle_bits(2, 3'd7);
    checks++;
    if (got.size() !== 1) begin
      failures++; $display("FAIL rx_en_resume pulses got=%0d want=1", got.size());
    end else begin
      checks++;
      if (got[0] !== want) begin failures++; $display("FAIL rx_en_resume frame got=%h want=%h", got[0], want); end
    end
  endtask

  task automatic test_reset_mid_frame();
    send_frame(8'h5A, 1'b0, 1'b0, FRAME_BITS, 3'd7);
    idle_bits(2, 3'd7);
    send_frame(8'hC3, 1'b0, 1'b1, 4, 3'd7);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR} !== 11'h000) begin
      failures++;
      $display("FAIL reset_mid_frame outputs got=%h/%b/%b/%b want=00/0/0/0", Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR);
    end
    reset = 1'b0;
    got.delete();
    idle_bits(2, 3'd7);
    checks++;
    if (got.size() !== 0) begin failures++; $display("FAIL reset_mid_frame pulses got=%0d want=0", got.size()); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] want [2];
    got.delete();
    want[0] = model(8'h11, 1'b0, 1'b1);
    want[1] = model(8'h22, 1'b0, 1'b1);
    send_frame(8'h11, 1'b0, 1'b1, FRAME_BITS, 3'd7);
    send_frame(8'h22, 1'b0, 1'b1, FRAME_BITS, 3'd7);
    idle_bits(2, 3'd7);
    checks++;
    if (got.size() !== 2) begin
      failures++; $display("FAIL back_to_back pulses got=%0d want=2", got.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got[i] !== want[i]) begin
          failures++; $display("FAIL back_to_back frame%0d got=%h want=%h", i, got[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_baud_latch();
    logic [9:0] want;
    got.delete();
    want = model(8'h6D, 1'b1, 1'b1);
    fork
      send_frame(8'h6D, 1'b1, 1'b1, FRAME_BITS, 3'd7);
      begin
        repeat (3 * bit_clks(3'd7)) @(negedge clk);
        baud_select = 3'd3;
      end
    join
    idle_bits(2, 3'd7);
    baud_select = 3'd7;
    checks++;
    if (got.size() !== 1) begin
      failures++; $display("FAIL baud_latch pulses got=%0d want=1", got.size());
    end else begin
      checks++;
      if (got[0] !== want) begin failures++; $display("FAIL baud_latch frame got=%h want=%h", got[0], want); end
    end
  endtask

  task automatic test_random();
    logic [9:0] want[$];
    logic [7:0] d;
    logic       par;
    logic       stop;
    logic [2:0] sel;
    got.delete();
    for (int n = 0; n < 8; n++) begin
      sel  = 3'($urandom_range(5, 7));
      d    = 8'($urandom);
      par  = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 3) != 0);
      baud_select = sel;
      want.push_back(model(d, par, stop));
      send_frame(d, par, stop, FRAME_BITS, sel);
      // A low stop bit needs idle line afterwards before the next start edge.
      idle_bits(stop ? int'($urandom_range(0, 1)) : 2, sel);
    end
    idle_bits(2, 3'd5);
    baud_select = 3'd7;
    checks++;
    if (got.size() !== want.size()) begin
      failures++; $display("FAIL random pulses got=%0d want=%0d", got.size(), want.size());
    end else begin
      for (int i = 0; i < want.size(); i++) begin
        checks++;
        if (got[i] !== want[i]) begin
          failures++; $display("FAIL random frame%0d got=%h want=%h", i, got[i], want[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_parity_error();
    test_framing_error();
    test_glitch();
    test_rx_en_abort();
    test_reset_mid_frame();
    test_back_to_back();
    test_baud_latch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
